// File: rtl/adc_ddr_delay_calibrator_if.sv
// ---------------------------------------------------------------------------
// adc_ddr_delay_calibrator_if
// Signal bundle between one delay calibrator and its surroundings: the
// training request, the capture block's pattern-check result, the IDELAY
// tap code and load strobe, and the calibration status/result.
//
// Handshake: cal_start is a level request that the calibrator accepts only
// while it is idle (IDLE, DONE or FAIL). Acceptance is the rising edge on
// which cal_busy goes high on the following cycle. While cal_busy is high
// further cal_start pulses are ignored. tap_load is a one-cycle strobe with
// tap_value valid in the same cycle; there is no back-pressure on it.
//
// modport master : the calibrator itself
// modport slave  : the environment (capture block / IDELAY / controller)
// state_dbg      : FSM state of the calibrator, for observation only
// ---------------------------------------------------------------------------
interface adc_ddr_delay_calibrator_if #(
    parameter int TAP_WIDTH = 5
) ();
    logic                 cal_start;
    logic                 test_pattern_valid;
    logic [TAP_WIDTH-1:0] tap_value;
    logic                 tap_load;
    logic                 cal_busy;
    logic                 cal_done;
    logic                 cal_fail;
    logic [TAP_WIDTH-1:0] win_start;
    logic [TAP_WIDTH:0]   win_len;
    logic [3:0]           state_dbg;

    modport master (
        input  cal_start, test_pattern_valid,
        output tap_value, tap_load, cal_busy, cal_done, cal_fail,
               win_start, win_len, state_dbg
    );

    modport slave (
        output cal_start, test_pattern_valid,
        input  tap_value, tap_load, cal_busy, cal_done, cal_fail,
               win_start, win_len, state_dbg
    );
endinterface

// File: rtl/adc_ddr_delay_calibrator.sv
// ---------------------------------------------------------------------------
// adc_ddr_delay_calibrator
// Per-channel IDELAY training controller. While the ADC sends its test
// pattern, every tap 0..2**TAP_WIDTH-1 is loaded, allowed to settle, and
// scored with test_pattern_valid. The longest contiguous run of passing taps
// is kept (earliest wins on a tie) and the tap at its lower-middle centre is
// loaded. If no tap passes, DEFAULT_TAP is loaded and the FAIL state entered.
//
// Ports
//   aclk     : capture clock, rising edge
//   aresetn  : asynchronous active-low reset
//   cal_if   : master side of adc_ddr_delay_calibrator_if
//              (cal_start, test_pattern_valid in; tap_value, tap_load,
//               cal_busy, cal_done, cal_fail, win_start, win_len,
//               state_dbg out)
// ---------------------------------------------------------------------------
module adc_ddr_delay_calibrator #(
    parameter int TAP_WIDTH     = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int CHECK_CYCLES  = 256,
    parameter int DEFAULT_TAP   = 16
) (
    input  logic aclk,
    input  logic aresetn,
    adc_ddr_delay_calibrator_if.master cal_if
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CHECK_LAST  = CNT_W'(CHECK_CYCLES - 1);
    localparam logic [TAP_WIDTH-1:0] TAP_MAX     = '1;
    localparam logic [TAP_WIDTH-1:0] DEF_TAP     = TAP_WIDTH'(DEFAULT_TAP);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_EVAL,
        S_CENTER,
        S_FINAL_LOAD,
        S_FINAL_SETTLE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state, state_nxt;

    logic [TAP_WIDTH-1:0] idx;
    logic [CNT_W-1:0]     cnt;
    logic                 tap_pass;
    logic [TAP_WIDTH-1:0] run_start;
    logic [TAP_WIDTH:0]   run_len;
    logic [TAP_WIDTH-1:0] best_start;
    logic [TAP_WIDTH:0]   best_len;
    logic [TAP_WIDTH-1:0] tap_q;
    logic                 no_window;

    logic                 idle_like;
    logic [TAP_WIDTH:0]   ext_len;
    logic [TAP_WIDTH-1:0] ext_start;
    logic                 win_close;
    logic [TAP_WIDTH:0]   center_sum;

    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_FAIL);

    // Window bookkeeping for the EVAL cycle. A failing tap leaves the running
    // length untouched so that "closing" compares the window that just ended.
    // The last tap always closes, so a window reaching the top tap is scored.
    always_comb begin
        ext_len    = tap_pass ? (run_len + 1'b1) : run_len;
        ext_start  = (tap_pass && (run_len == '0)) ? idx : run_start;
        win_close  = !tap_pass || (idx == TAP_MAX);
        // Lower middle of the best window; best_start + (len-1)/2 never
        // exceeds the top tap, so the low TAP_WIDTH bits are exact.
        center_sum = {1'b0, best_start} + ((best_len - 1'b1) >> 1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_FAIL: if (cal_if.cal_start) state_nxt = S_LOAD;
            S_LOAD:                 state_nxt = S_SETTLE;
            S_SETTLE:               if (cnt == SETTLE_LAST) state_nxt = S_CHECK;
            S_CHECK:                if (!cal_if.test_pattern_valid || (cnt == CHECK_LAST)) state_nxt = S_EVAL;
            S_EVAL:                 state_nxt = (idx == TAP_MAX) ? S_CENTER : S_LOAD;
            S_CENTER:               state_nxt = S_FINAL_LOAD;
            S_FINAL_LOAD:           state_nxt = S_FINAL_SETTLE;
            S_FINAL_SETTLE:         if (cnt == SETTLE_LAST) state_nxt = no_window ? S_FAIL : S_DONE;
            default:                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idx        <= '0;
            cnt        <= '0;
            tap_pass   <= 1'b0;
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            tap_q      <= DEF_TAP;
            no_window  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (cal_if.cal_start) begin
                        idx        <= '0;
                        cnt        <= '0;
                        tap_pass   <= 1'b0;
                        run_start  <= '0;
                        run_len    <= '0;
                        best_start <= '0;
                        best_len   <= '0;
                        tap_q      <= '0;
                        no_window  <= 1'b0;
                    end
                end
                S_SETTLE, S_FINAL_SETTLE: begin
                    cnt <= (cnt == SETTLE_LAST) ? '0 : cnt + 1'b1;
                end
                S_CHECK: begin
                    if (!cal_if.test_pattern_valid) begin
                        tap_pass <= 1'b0;
                        cnt      <= '0;
                    end else if (cnt == CHECK_LAST) begin
                        tap_pass <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (win_close) begin
                        run_len <= '0;
                        if (ext_len > best_len) begin
                            best_len   <= ext_len;
                            best_start <= ext_start;
                        end
                    end else begin
                        run_len   <= ext_len;
                        run_start <= ext_start;
                    end
                    if (idx != TAP_MAX) begin
                        idx   <= idx + 1'b1;
                        tap_q <= idx + 1'b1;
                    end
                end
                S_CENTER: begin
                    if (best_len != '0) begin
                        tap_q <= center_sum[TAP_WIDTH-1:0];
                    end else begin
                        tap_q     <= DEF_TAP;
                        no_window <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cal_if.tap_value = tap_q;
    assign cal_if.tap_load  = (state == S_LOAD) || (state == S_FINAL_LOAD);
    assign cal_if.cal_busy  = !idle_like;
    assign cal_if.cal_done  = (state == S_DONE);
    assign cal_if.cal_fail  = (state == S_FAIL);
    assign cal_if.win_start = best_start;
    assign cal_if.win_len   = best_len;
    assign cal_if.state_dbg = state;

endmodule

// File: tb/tb_adc_ddr_delay_calibrator.sv
// ---------------------------------------------------------------------------
// tb_adc_ddr_delay_calibrator
// Bench for adc_ddr_delay_calibrator (TAP_WIDTH=5, SETTLE=4, CHECK=8,
// DEFAULT_TAP=16). test_pattern_valid is a function of the most recently
// loaded tap (a pass mask plus an optional single-sample glitch). Expected
// results come from a window model over the per-tap pass/fail list.
// ---------------------------------------------------------------------------
module tb_adc_ddr_delay_calibrator;

    localparam int TW = 5;
    localparam int S  = 4;
    localparam int C  = 8;
    localparam int D  = 16;
    localparam int NT = 32;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;

    always #5 aclk = ~aclk;

    adc_ddr_delay_calibrator_if #(.TAP_WIDTH(TW)) cal_if ();

    adc_ddr_delay_calibrator #(
        .TAP_WIDTH    (TW),
        .SETTLE_CYCLES(S),
        .CHECK_CYCLES (C),
        .DEFAULT_TAP  (D)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .cal_if (cal_if.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- pattern source and load monitor ----------------
    logic [31:0] pass_mask   = '0;
    int          glitch_tap  = -1;
    int          glitch_samp = 0;
    int          cur_tap     = 0;
    int          since       = 0;
    int          cyc         = 0;
    int          load_cyc[$];
    int          load_val[$];

    always @(posedge aclk) cyc++;

    // Cycle after a load strobe counts as since=0; the k-th CHECK sample is
    // taken in the cycle where since == S + k.
    always @(negedge aclk) begin
        if (cal_if.tap_load) begin
            load_cyc.push_back(cyc);
            load_val.push_back(int'(cal_if.tap_value));
            cur_tap = int'(cal_if.tap_value);
            since   = 0;
        end else begin
            since++;
        end
        cal_if.test_pattern_valid = pass_mask[cur_tap] &&
                                    !(cur_tap == glitch_tap && since == S + glitch_samp);
    end

    // ---------------- reference model ----------------
    function automatic bit tap_ok(input logic [31:0] mask, input int gt, input int t);
        return mask[t] && (t != gt);
    endfunction

    // Longest run of passing taps; a later run must be strictly longer to win.
    task automatic model(input logic [31:0] mask, input int gt,
                         output int es, output int el, output int etap);
        int run;
        run = 0; es = 0; el = 0;
        for (int t = 0; t < NT; t++) begin
            run = tap_ok(mask, gt, t) ? run + 1 : 0;
            if (run > el) begin
                el = run;
                es = t - run + 1;
            end
        end
        etap = (el > 0) ? es + (el - 1) / 2 : D;
    endtask

    // Cycles from one tap's load strobe to the next one.
    function automatic int tap_cycles(input logic [31:0] mask, input int gt, input int gs, input int t);
        int chk_len;
        if (tap_ok(mask, gt, t)) chk_len = C;
        else if (!mask[t])       chk_len = 1;
        else                     chk_len = gs;
        return 2 + S + chk_len + ((t == NT - 1) ? 1 : 0);
    endfunction

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // ---------------- driver ----------------
    task automatic check_reset_values(input string name);
        chk({name, " tap_value"}, 32'(cal_if.tap_value), 32'(D));
        chk({name, " tap_load"},  32'(cal_if.tap_load),  0);
        chk({name, " cal_busy"},  32'(cal_if.cal_busy),  0);
        chk({name, " cal_done"},  32'(cal_if.cal_done),  0);
        chk({name, " cal_fail"},  32'(cal_if.cal_fail),  0);
        chk({name, " win_start"}, 32'(cal_if.win_start), 0);
        chk({name, " win_len"},   32'(cal_if.win_len),   0);
    endtask

    task automatic run_cal(input logic [31:0] mask, input int gt, input int gs,
                           input bit poke, input string name);
        int es, el, etap, n;
        bit efail;
        pass_mask   = mask;
        glitch_tap  = gt;
        glitch_samp = gs;
        model(mask, gt, es, el, etap);
        efail = (el == 0);

        @(negedge aclk);
        load_cyc.delete();
        load_val.delete();
        cal_if.cal_start = 1'b1;
        @(negedge aclk);
        cal_if.cal_start = 1'b0;
        chk({name, " busy after start"}, 32'(cal_if.cal_busy), 1);
        chk({name, " done cleared"},     32'(cal_if.cal_done), 0);

        n = 0;
        while (!(cal_if.cal_done || cal_if.cal_fail) && n < 2000) begin
            cal_if.cal_start = poke && (n == 100);
            @(negedge aclk);
            n++;
        end
        cal_if.cal_start = 1'b0;
        chk({name, " finished in budget"}, 32'(n < 2000), 1);

        chk({name, " cal_done"},  32'(cal_if.cal_done),  32'(!efail));
        chk({name, " cal_fail"},  32'(cal_if.cal_fail),  32'(efail));
        chk({name, " cal_busy"},  32'(cal_if.cal_busy),  0);
        chk({name, " win_start"}, 32'(cal_if.win_start), 32'(es));
        chk({name, " win_len"},   32'(cal_if.win_len),   32'(el));
        chk({name, " tap_value"}, 32'(cal_if.tap_value), 32'(etap));
        chk({name, " load count"}, 32'(load_val.size()), NT + 1);
        if (load_val.size() == NT + 1) begin
            chk({name, " final load tap"}, 32'(load_val[NT]), 32'(etap));
            for (int k = 0; k < NT; k++) begin
                chk($sformatf("%s load tap %0d", name, k), 32'(load_val[k]), 32'(k));
                chk($sformatf("%s tap %0d cycles", name, k),
                    32'(load_cyc[k + 1] - load_cyc[k]), 32'(tap_cycles(mask, gt, gs, k)));
            end
        end

        // Result must stay put while idle.
        repeat (5) @(negedge aclk);
        chk({name, " tap held"}, 32'(cal_if.tap_value), 32'(etap));
    endtask

    initial begin
        int n;
        cal_if.cal_start = 1'b0;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check_reset_values("reset");
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        run_cal(32'hFFFF_FFFF, -1, 0, 1'b0, "all_pass");
        run_cal(rng(10, 20),   -1, 0, 1'b0, "mid_window");
        run_cal(rng(3, 6) | rng(20, 23), -1, 0, 1'b0, "tie");
        run_cal(rng(3, 6) | rng(20, 24), -1, 0, 1'b0, "later_longer");
        run_cal(rng(28, 31),   -1, 0, 1'b0, "top_edge");
        run_cal(32'h0,         -1, 0, 1'b0, "all_fail");
        run_cal(rng(11, 20),   15, 6, 1'b1, "glitch_poke");

        // Reset in the middle of the CHECK phase of tap 12.
        pass_mask  = rng(10, 20);
        glitch_tap = -1;
        @(negedge aclk);
        cal_if.cal_start = 1'b1;
        @(negedge aclk);
        cal_if.cal_start = 1'b0;
        n = 0;
        while (!(cal_if.tap_load && cal_if.tap_value == 5'd12) && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        chk("reach tap 12", 32'(n < 2000), 1);
        repeat (S + 3) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check_reset_values("after_reset");

        run_cal(rng(10, 20), -1, 0, 1'b0, "rescan");

        for (int r = 0; r < 4; r++) begin
            logic [31:0] m;
            m = $urandom() | ($urandom() & $urandom());
            run_cal(m, int'($urandom_range(0, NT - 1)), int'($urandom_range(1, C)), 1'b0,
                    $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
